// File: rtl/pulse_debounce_pkg.sv
// pulse_pkg: shared FSM state encoding and glitch counter limits for pulse_debounce
package pulse_pkg;
  typedef enum logic [1:0] {LOW, ARM_HIGH, HIGH, ARM_LOW} state_t;
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;
endpackage

// File: rtl/pulse_debounce_if.sv
// pulse_debounce_if: raw input and debounced outputs; master drives raw_in, slave (debouncer) drives the rest
interface pulse_debounce_if;
  import pulse_pkg::*;
  logic raw_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic [GLITCH_W-1:0] glitch_cnt;
  modport master(output raw_in, input level_out, rise_pulse, fall_pulse, glitch_cnt);
  modport slave(input raw_in, output level_out, rise_pulse, fall_pulse, glitch_cnt);
endinterface

// File: rtl/pulse_debounce_sync_ff.sv
// sync_ff: N-stage reset-to-0 synchronizer; clk/rst_n, d async in, q synchronized out (last stage)
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr_d, sr_q;
  always_comb sr_d = {sr_q[N-2:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
  assign q = sr_q[N-1];
endmodule

// File: rtl/pulse_debounce.sv
// pulse_debounce: synchronise and debounce raw_in; clk, rst_n (async low), bus.slave carries raw_in, level_out, rise/fall strobes, glitch_cnt
module pulse_debounce
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input logic clk,
  input logic rst_n,
  pulse_debounce_if.slave bus
);
  logic s, last, abort;
  state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [GLITCH_W-1:0] glitch_d, glitch_q;
  logic level_d, level_q, rise_d, rise_q, fall_d, fall_q;
  sync_ff #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(bus.raw_in), .q(s));
  assign last = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    level_d = level_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    abort = 1'b0;
    case (state_q)
      LOW: if (s) begin
        state_d = ARM_HIGH;
        cnt_d = '0;
      end
      ARM_HIGH: if (!s) begin
        state_d = LOW;
        abort = 1'b1;
      end else if (last) begin
        state_d = HIGH;
        level_d = 1'b1;
        rise_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      HIGH: if (!s) begin
        state_d = ARM_LOW;
        cnt_d = '0;
      end
      ARM_LOW: if (s) begin
        state_d = HIGH;
        abort = 1'b1;
      end else if (last) begin
        state_d = LOW;
        level_d = 1'b0;
        fall_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = LOW;
    endcase
    // saturate rather than wrap so a stuck-toggling input reads as "many"
    glitch_d = (abort && glitch_q != GLITCH_MAX) ? glitch_q + 1'b1 : glitch_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q <= '0;
      glitch_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      glitch_q <= glitch_d;
      level_q <= level_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  assign bus.level_out = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.glitch_cnt = glitch_q;
endmodule

// File: tb/tb_pulse_debounce.sv
// tb_pulse_debounce: directed checks of pulse_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
module tb_pulse_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int rise_n = 0;
  int fall_n = 0;
  pulse_debounce_if bus();
  pulse_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rise_pulse) rise_n++;
    if (bus.fall_pulse) fall_n++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chkb(input string tag, input logic o, input logic e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic chki(input string tag, input int o, input int e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic chk_outs(input string tag, input logic lv, input logic r, input logic f, input int g);
    chkb({tag, "_level"}, bus.level_out, lv);
    chkb({tag, "_rise"}, bus.rise_pulse, r);
    chkb({tag, "_fall"}, bus.fall_pulse, f);
    chki({tag, "_glitch"}, int'(bus.glitch_cnt), g);
  endtask
  initial begin
    bus.raw_in = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_outs("idle", 1'b0, 1'b0, 1'b0, 0);
    // clean rise: sampled at E0, accepted at E0+6
    bus.raw_in = 1'b1;
    repeat (6) tick();
    chk_outs("rise_pre", 1'b0, 1'b0, 1'b0, 0);
    tick();
    chk_outs("rise_acc", 1'b1, 1'b1, 1'b0, 0);
    tick();
    chk_outs("rise_post", 1'b1, 1'b0, 1'b0, 0);
    // clean fall
    bus.raw_in = 1'b0;
    repeat (6) tick();
    chk_outs("fall_pre", 1'b1, 1'b0, 1'b0, 0);
    tick();
    chk_outs("fall_acc", 1'b0, 1'b0, 1'b1, 0);
    tick();
    chk_outs("fall_post", 1'b0, 1'b0, 1'b0, 0);
    // short glitch, two cycles high
    bus.raw_in = 1'b1;
    repeat (2) tick();
    bus.raw_in = 1'b0;
    repeat (10) tick();
    chk_outs("glitch", 1'b0, 1'b0, 1'b0, 1);
    chki("glitch_rises", rise_n, 1);
    // three 1-cycle bounces then held high
    for (int i = 0; i < 3; i++) begin
      bus.raw_in = 1'b1;
      tick();
      bus.raw_in = 1'b0;
      tick();
    end
    bus.raw_in = 1'b1;
    repeat (6) tick();
    chk_outs("bounce_pre", 1'b0, 1'b0, 1'b0, 4);
    tick();
    chk_outs("bounce_acc", 1'b1, 1'b1, 1'b0, 4);
    tick();
    chk_outs("bounce_post", 1'b1, 1'b0, 1'b0, 4);
    chki("bounce_rises", rise_n, 2);
    bus.raw_in = 1'b0;
    repeat (12) tick();
    chk_outs("bounce_fall", 1'b0, 1'b0, 1'b0, 4);
    // reset two cycles into ARM_HIGH, raw held high through release
    bus.raw_in = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk_outs("rst_pre", 1'b0, 1'b0, 1'b0, 0);
    tick();
    chk_outs("rst_acc", 1'b1, 1'b1, 1'b0, 0);
    tick();
    chkb("rst_post_rise", bus.rise_pulse, 1'b0);
    bus.raw_in = 1'b0;
    repeat (12) tick();
    chk_outs("rst_fall", 1'b0, 1'b0, 1'b0, 0);
    chki("rises_before_sat", rise_n, 3);
    chki("falls_before_sat", fall_n, 3);
    // toggle every cycle: ~300 aborts, must saturate at 255
    for (int i = 0; i < 600; i++) begin
      bus.raw_in = ~bus.raw_in;
      tick();
    end
    chk_outs("sat", 1'b0, 1'b0, 1'b0, 255);
    bus.raw_in = 1'b0;
    repeat (8) tick();
    chk_outs("sat_hold", 1'b0, 1'b0, 1'b0, 255);
    chki("sat_rises", rise_n, 3);
    chki("sat_falls", fall_n, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pulse_debounce.md
# pulse_debounce

Upstream conditioning stage for the pulse stretcher. It takes an asynchronous, possibly bouncing raw input and synchronises it into `clk`. Only a level held stable for a programmable number of cycles is accepted. It emits a debounced level plus one-cycle rise/fall strobes; `rise_pulse` drives the stretcher's `in_pulse` directly.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth; legal range ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles needed to accept a new level; legal range ≥2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: stability counter width; derived, not overridden.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `raw_in` input 1: asynchronous raw level, e.g. button or external strobe.
- `level_out` output 1: debounced level; registered.
- `rise_pulse` output 1: one-cycle strobe when the accepted level goes 0→1; registered.
- `fall_pulse` output 1: one-cycle strobe when the accepted level goes 1→0; registered.
- `glitch_cnt` output 8: saturating count of rejected transitions (bounces).

## Operation
- **Synchronizer:** `SYNC_STAGES` flops, all reset to 0. The synchronized signal `s` is the last stage.
- **FSM states:**
  - LOW: `level_out` is 0.
    - `s`=1: go to ARM_HIGH with `cnt` cleared to 0.
  - ARM_HIGH:
    - `s`=0: return to LOW and increment `glitch_cnt`.
    - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1: go to HIGH, set `level_out`=1, strobe `rise_pulse`.
    - `s`=1 otherwise: increment `cnt`.
  - HIGH: `level_out` is 1.
    - `s`=0: go to ARM_LOW with `cnt` cleared to 0.
  - ARM_LOW:
    - `s`=1: return to HIGH and increment `glitch_cnt`.
    - `s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1: go to LOW, set `level_out`=0, strobe `fall_pulse`.
    - `s`=0 otherwise: increment `cnt`.
- **Output behaviour in ARM states:** `level_out` holds the previous accepted level. No strobe is issued on an aborted arm.
- **Strobes:** `rise_pulse` and `fall_pulse` are high for exactly one cycle. They are mutually exclusive and never asserted on consecutive cycles, because a new level needs at least `DEBOUNCE_CYCLES`+1 cycles.
- **`glitch_cnt`:** saturates at 255, with no wrap. It is cleared only by reset.
- **Counter:** `cnt` never exceeds `DEBOUNCE_CYCLES`-1. It is cleared on every ARM entry.

## Timing
- **Reset values:** `level_out`=0, `rise_pulse`=0, `fall_pulse`=0, `glitch_cnt`=0, state LOW, `cnt`=0, synchronizer all 0.
- **Reset assertion:** asynchronous; outputs clear immediately, mid-arm or mid-strobe included.
- **Latency:** `raw_in` is first sampled at a new value at edge E0 and then held. `s` changes after edge E0+`SYNC_STAGES`-1. The FSM enters ARM at edge E0+`SYNC_STAGES`. The accept transition happens at edge E0+`SYNC_STAGES`+`DEBOUNCE_CYCLES`, when `level_out` changes and the strobe rises. The strobe falls at the next edge. Total latency is `SYNC_STAGES`+`DEBOUNCE_CYCLES` cycles (18 with defaults).
- **Aborted arm:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles aborts the arm. The state returns at the edge where `s` reverts, and `glitch_cnt` increments at that same edge.
- **Raw input held high through reset release:** treated as a fresh rise. `rise_pulse` fires at the normal latency after the first edge following deassertion.
- **`raw_in` toggling every cycle:** never accepted. `glitch_cnt` increments roughly every 2 cycles until it saturates.

## Structure
- **Shared package `pulse_pkg`:**
  - `state_t` enum: LOW, ARM_HIGH, HIGH, ARM_LOW.
  - `GLITCH_W`=8 and `GLITCH_MAX`=255.
- **Sub-module `sync_ff`:**
  - Parameterised N-stage synchronizer; ports `clk`, `rst_n`, `d`, `q`.
  - Reused by other async inputs in the design.
- **Top-level logic:** one FSM with one stability counter and one glitch counter.

## Test plan
Benches use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.
1. **Clean rise:** `raw_in` 0→1 sampled at edge 10, held high → `rise_pulse` high only in the cycle after edge 16; `level_out`=1 from edge 16; `glitch_cnt`=0.
2. **Short glitch:** `raw_in` high for 2 cycles then low → `level_out` stays 0; no strobes; `glitch_cnt`=1.
3. **Bounce then settle:** 3 high/low bounces of 1 cycle each, then held high → `glitch_cnt`=3; exactly one `rise_pulse`, 6 cycles after the final stable rise is sampled.
4. **Clean fall:** from HIGH, `raw_in` 1→0 held → `fall_pulse` one cycle 6 cycles later; `level_out`=0.
5. **Reset mid-arm:** `rst_n` asserted 2 cycles into ARM_HIGH → all outputs 0 immediately. `raw_in` is held high through release → `rise_pulse` fires 6 cycles after the first post-release edge.
6. **Saturation:** `raw_in` toggling every cycle for 600 cycles → `glitch_cnt`=255 and stays there; `level_out` stays 0; no strobes.
